// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: producer drives operands and
// out_ready, the ALU drives in_ready and the registered result with status flags.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Ain;
  logic [WIDTH-1:0] Bin;
  logic [2:0]       ALUop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             Z;
  logic             N;
  logic             V;

  modport master (
    output in_valid, Ain, Bin, ALUop, out_ready,
    input  in_ready, out_valid, out, Z, N, V
  );

  modport slave (
    input  in_valid, Ain, Bin, ALUop, out_ready,
    output in_ready, out_valid, out, Z, N, V
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: s1 captures operands, s2 computes and registers the
// result with N/V/Z; valid/ready on both sides with same-cycle back-pressure.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      reset,
  alu_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_MVN = 3'b011,
    OP_ORR = 3'b100,
    OP_EOR = 3'b101,
    OP_LSL = 3'b110,
    OP_LSR = 3'b111
  } alu_op_e;

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] a_q, b_q;
  alu_op_e          op_q;
  logic             s1_valid_q;

  logic [WIDTH-1:0] out_q;
  logic             z_q, n_q, v_q, out_valid_q;

  logic [WIDTH-1:0] sum, diff, res_d;
  logic             v_d, z_d, n_d;
  logic             s1_ready, s2_ready, s1_fire, s2_fire;

  // Back-pressure ripples combinationally from out_ready to in_ready.
  assign s2_ready     = !out_valid_q | bus.out_ready;
  assign s1_ready     = !s1_valid_q | s2_ready;
  assign bus.in_ready = s1_ready & !reset;
  assign s1_fire      = bus.in_valid & bus.in_ready;
  assign s2_fire      = s1_valid_q & s2_ready;

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  always_comb begin
    res_d = '0;
    v_d   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d = sum;
        v_d   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        res_d = diff;
        v_d   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_AND:  res_d = a_q & b_q;
      OP_MVN:  res_d = ~b_q;
      OP_ORR:  res_d = a_q | b_q;
      OP_EOR:  res_d = a_q ^ b_q;
      OP_LSL:  res_d = {b_q[WIDTH-2:0], 1'b0};
      OP_LSR:  res_d = {1'b0, b_q[WIDTH-1:1]};
      default: res_d = '0;
    endcase
    z_d = (res_d == '0);
    n_d = res_d[MSB];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      s1_valid_q <= 1'b0;
    end else if (s1_fire) begin
      a_q        <= bus.Ain;
      b_q        <= bus.Bin;
      op_q       <= alu_op_e'(bus.ALUop);
      s1_valid_q <= 1'b1;
    end else if (s2_fire) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Result regs only move on s2_fire, so they stay frozen while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (s2_fire) begin
      out_q       <= res_d;
      z_q         <= z_d;
      n_q         <= n_d;
      v_q         <= v_d;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out       = out_q;
  assign bus.Z         = z_q;
  assign bus.N         = n_q;
  assign bus.V         = v_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed + random bench for alu_pipe against an arithmetic reference model
// and an in-order scoreboard queue; a WIDTH=8 instance checks wraparound.
module tb_alu_pipe;

  typedef struct packed {
    logic [15:0] r;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(16)) b16();
  alu_pipe_if #(.WIDTH(8))  b8();

  alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));
  alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  exp_t        q[$];
  logic        held_v = 1'b0;
  logic [18:0] held   = '0;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] op);
    exp_t e;
    int   ua, ub, sa, sb, s, r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    s = 0;
    r = 0;
    e.v = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; r = (ua + ub) % 65536;         e.v = (s > 32767) || (s < -32768); end
      3'd1: begin s = sa - sb; r = (ua - ub + 65536) % 65536; e.v = (s > 32767) || (s < -32768); end
      3'd2: r = int'(a & b);
      3'd3: r = 65535 - ub;
      3'd4: r = int'(a | b);
      3'd5: r = int'(a ^ b);
      3'd6: r = (ub * 2) % 65536;
      default: r = ub / 2;
    endcase
    e.r = 16'(r);
    e.z = (r == 0);
    e.n = (r >= 32768);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dchk(input string tag, input logic [15:0] r, input logic z,
                      input logic n, input logic v);
    chk(tag, {12'b0, b16.out_valid, b16.out, b16.Z, b16.N, b16.V},
             {12'b0, 1'b1, r, z, n, v});
  endtask

  // One clock: drive at posedge+1, sample handshake at negedge, return at posedge+1.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] op, input logic ordy, output logic acc);
    exp_t e;
    b16.in_valid  = v;
    b16.Ain       = a;
    b16.Bin       = b;
    b16.ALUop     = op;
    b16.out_ready = ordy;
    @(negedge clk);
    if (held_v) chk("hold", {13'b0, b16.out, b16.Z, b16.N, b16.V}, {13'b0, held});
    held_v = b16.out_valid & !ordy & !reset;
    held   = {b16.out, b16.Z, b16.N, b16.V};
    if (b16.out_valid === 1'b1 && ordy) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_out: observed out=%h with no op pending", b16.out);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("result", {13'b0, b16.out, b16.Z, b16.N, b16.V}, {13'b0, e});
        pops++;
      end
    end
    acc = v & b16.in_ready;
    if (acc) q.push_back(model(a, b, op));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc, seen;
    int          idx, n, pops0;
    logic [15:0] ba[4], bb[4];
    logic [15:0] exp_log[6];
    exp_log = '{16'h00F0, 16'hF00E, 16'hFFF1, 16'hFF01, 16'h1FE2, 16'h07F8};

    reset = 1'b1;
    b16.in_valid = 1'b0; b16.Ain = '0; b16.Bin = '0; b16.ALUop = '0; b16.out_ready = 1'b0;
    b8.in_valid  = 1'b0; b8.Ain  = '0; b8.Bin  = '0; b8.ALUop  = '0; b8.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {12'b0, b16.out_valid, b16.out, b16.Z, b16.N, b16.V}, 32'h0);
    chk("reset_in_ready", 32'(b16.in_ready), 32'h0);
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", 32'(b16.in_ready), 32'h1);

    // ADD overflow into the sign bit
    step(1, 16'h7FFF, 16'h0001, 3'd0, 1, acc);
    step(0, 16'h0, 16'h0, 3'd0, 1, acc);
    dchk("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b1);

    // SUB to zero then unsigned wrap with no signed overflow
    step(1, 16'h1234, 16'h1234, 3'd1, 1, acc);
    step(1, 16'hFFFF, 16'h0001, 3'd0, 1, acc);
    dchk("sub_zero", 16'h0000, 1'b1, 1'b0, 1'b0);
    step(0, 16'h0, 16'h0, 3'd0, 1, acc);
    dchk("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      step(1, 16'hF0F0, 16'h0FF1, 3'(i + 2), 1, acc);
      step(0, 16'h0, 16'h0, 3'd0, 1, acc);
      chk($sformatf("logic_op%0d", i + 2), {15'b0, b16.out_valid, b16.out},
          {15'b0, 1'b1, exp_log[i]});
      chk($sformatf("logic_v%0d", i + 2), 32'(b16.V), 32'h0);
    end
    step(0, 16'h0, 16'h0, 3'd0, 1, acc);

    // Back-pressure: only two ops fit while out_ready is low
    for (int i = 0; i < 4; i++) begin
      ba[i] = 16'($urandom);
      bb[i] = 16'($urandom);
    end
    idx = 0;
    repeat (5) begin
      step(idx < 4, ba[idx], bb[idx], 3'd0, 0, acc);
      if (acc) idx++;
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    chk("bp_in_ready", 32'(b16.in_ready), 32'h0);
    chk("bp_first_held", {13'b0, b16.out, b16.Z, b16.N, b16.V}, {13'b0, q[0]});
    pops0 = pops;
    n = 0;
    while ((idx < 4 || q.size() > 0) && n < 30) begin
      step(idx < 4, ba[idx % 4], bb[idx % 4], 3'd0, 1, acc);
      if (acc) idx++;
      n++;
    end
    chk("bp_drain_count", 32'(pops - pops0), 32'd4);
    chk("bp_all_accepted", 32'(idx), 32'd4);

    // Reset with two ops in flight
    step(1, 16'($urandom), 16'($urandom), 3'd0, 0, acc);
    step(1, 16'($urandom), 16'($urandom), 3'd1, 0, acc);
    chk("pre_rst_full", {30'b0, b16.out_valid, b16.in_ready}, 32'h2);
    reset = 1'b1;
    step(0, 16'h0, 16'h0, 3'd0, 0, acc);
    chk("rst_flush", {12'b0, b16.out_valid, b16.out, b16.Z, b16.N, b16.V}, 32'h0);
    q.delete();
    reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      step(0, 16'h0, 16'h0, 3'd0, 1, acc);
      seen = seen | b16.out_valid;
    end
    chk("rst_no_stale", 32'(seen), 32'h0);

    // Random traffic with random stalls
    repeat (400) begin
      step($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
           3'($urandom_range(0, 7)), $urandom_range(0, 9) < 6, acc);
    end
    n = 0;
    while (q.size() > 0 && n < 20) begin
      step(0, 16'h0, 16'h0, 3'd0, 1, acc);
      n++;
    end
    chk("random_drained", 32'(q.size()), 32'd0);

    // WIDTH=8 wraparound
    b8.in_valid = 1'b1; b8.Ain = 8'hFF; b8.Bin = 8'h01; b8.ALUop = 3'd0;
    step(0, 16'h0, 16'h0, 3'd0, 1, acc);
    b8.in_valid = 1'b0;
    step(0, 16'h0, 16'h0, 3'd0, 1, acc);
    chk("w8_wrap", {20'b0, b8.out_valid, b8.out, b8.Z, b8.N, b8.V},
                   {20'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
